// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SERVE_INSTR = 2'd1,
        SERVE_DATA  = 2'd2
    } MemArbState_t;

    // Instruction fetches are always full-word reads.
    localparam logic [1:0] BYTESEL_ALL = 2'b11;

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle around the arbiter: instruction master, data master and shared bus.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic [19:1] instr_m_addr;
    logic [15:0] instr_m_data_in;
    logic        instr_m_access;
    logic        instr_m_ack;

    logic [19:1] data_m_addr;
    logic [15:0] data_m_data_in;
    logic [15:0] data_m_data_out;
    logic        data_m_access;
    logic        data_m_ack;
    logic        data_m_wr_en;
    logic [1:0]  data_m_bytesel;

    logic [19:1] q_m_addr;
    logic [15:0] q_m_data_in;
    logic [15:0] q_m_data_out;
    logic        q_m_access;
    logic        q_m_ack;
    logic        q_m_wr_en;
    logic [1:0]  q_m_bytesel;

    // Arbiter view: takes master requests and slave responses, drives the bus.
    modport master (
        input  instr_m_addr, instr_m_access,
        output instr_m_data_in, instr_m_ack,
        input  data_m_addr, data_m_data_out, data_m_access, data_m_wr_en, data_m_bytesel,
        output data_m_data_in, data_m_ack,
        output q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel,
        input  q_m_data_in, q_m_ack
    );

    // Environment view: the two masters and the shared-bus slave.
    modport slave (
        output instr_m_addr, instr_m_access,
        input  instr_m_data_in, instr_m_ack,
        output data_m_addr, data_m_data_out, data_m_access, data_m_wr_en, data_m_bytesel,
        input  data_m_data_in, data_m_ack,
        input  q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel,
        output q_m_data_in, q_m_ack
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter onto one shared memory bus; data wins contention except
// that the instruction master is guaranteed a grant after a bounded data streak.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int instr_starve_limit = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [19:1] instr_m_addr,
    output logic [15:0] instr_m_data_in,
    input  logic        instr_m_access,
    output logic        instr_m_ack,

    input  logic [19:1] data_m_addr,
    output logic [15:0] data_m_data_in,
    input  logic [15:0] data_m_data_out,
    input  logic        data_m_access,
    output logic        data_m_ack,
    input  logic        data_m_wr_en,
    input  logic [1:0]  data_m_bytesel,

    output logic [19:1] q_m_addr,
    input  logic [15:0] q_m_data_in,
    output logic [15:0] q_m_data_out,
    output logic        q_m_access,
    input  logic        q_m_ack,
    output logic        q_m_wr_en,
    output logic [1:0]  q_m_bytesel
);

    localparam int CW = (instr_starve_limit < 1) ? 1 : $clog2(instr_starve_limit + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(instr_starve_limit);

    MemArbState_t  state, state_nxt;
    logic [CW-1:0] starve_cnt, starve_cnt_nxt;
    logic          instr_due;

    assign instr_due = (starve_cnt == STARVE_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // A grant is held until the slave acks, regardless of the master's access.
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        case (state)
            IDLE: begin
                if (data_m_access && !(instr_m_access && instr_due)) begin
                    state_nxt = SERVE_DATA;
                    if (instr_m_access && !instr_due)
                        starve_cnt_nxt = starve_cnt + CW'(1);
                end else if (instr_m_access) begin
                    state_nxt      = SERVE_INSTR;
                    starve_cnt_nxt = '0;
                end
            end
            SERVE_INSTR, SERVE_DATA: begin
                if (q_m_ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        q_m_access   = 1'b0;
        q_m_addr     = '0;
        q_m_data_out = '0;
        q_m_wr_en    = 1'b0;
        q_m_bytesel  = '0;
        instr_m_ack  = 1'b0;
        data_m_ack   = 1'b0;
        case (state)
            SERVE_INSTR: begin
                q_m_access  = 1'b1;
                q_m_addr    = instr_m_addr;
                q_m_bytesel = BYTESEL_ALL;
                instr_m_ack = q_m_ack;
            end
            SERVE_DATA: begin
                q_m_access   = 1'b1;
                q_m_addr     = data_m_addr;
                q_m_data_out = data_m_data_out;
                q_m_wr_en    = data_m_wr_en;
                q_m_bytesel  = data_m_bytesel;
                data_m_ack   = q_m_ack;
            end
            default: ;
        endcase
    end

    // Read data fans out to both masters; held at zero only while in reset.
    assign instr_m_data_in = reset ? q_m_data_in : '0;
    assign data_m_data_in  = reset ? q_m_data_in : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level grant model, random slave.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIMIT = 4;

  typedef struct {
    int          who;   // 1 = instruction master, 2 = data master
    logic [19:1] addr;
    logic        wr;
    logic [15:0] wdata;
    logic [1:0]  bsel;
  } grant_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;

  mem_arbiter_if mif();

  always #5 clk = ~clk;

  mem_arbiter #(.instr_starve_limit(LIMIT)) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_m_addr    (mif.instr_m_addr),
    .instr_m_data_in (mif.instr_m_data_in),
    .instr_m_access  (mif.instr_m_access),
    .instr_m_ack     (mif.instr_m_ack),
    .data_m_addr     (mif.data_m_addr),
    .data_m_data_in  (mif.data_m_data_in),
    .data_m_data_out (mif.data_m_data_out),
    .data_m_access   (mif.data_m_access),
    .data_m_ack      (mif.data_m_ack),
    .data_m_wr_en    (mif.data_m_wr_en),
    .data_m_bytesel  (mif.data_m_bytesel),
    .q_m_addr        (mif.q_m_addr),
    .q_m_data_in     (mif.q_m_data_in),
    .q_m_data_out    (mif.q_m_data_out),
    .q_m_access      (mif.q_m_access),
    .q_m_ack         (mif.q_m_ack),
    .q_m_wr_en       (mif.q_m_wr_en),
    .q_m_bytesel     (mif.q_m_bytesel)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, and how many contended data wins in a row.
  grant_t exp_q[$];
  int     m_owner  = 0;
  int     m_streak = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner  <= 0;
      m_streak <= 0;
      exp_q.delete();
    end else if (m_owner == 0) begin
      if (mif.data_m_access && !(mif.instr_m_access && m_streak == LIMIT)) begin
        exp_q.push_back('{2, mif.data_m_addr, mif.data_m_wr_en, mif.data_m_data_out, mif.data_m_bytesel});
        m_owner <= 2;
        if (mif.instr_m_access) m_streak <= m_streak + 1;
      end else if (mif.instr_m_access) begin
        exp_q.push_back('{1, mif.instr_m_addr, 1'b0, 16'h0000, 2'b11});
        m_owner  <= 1;
        m_streak <= 0;
      end
    end else if (mif.q_m_ack) begin
      m_owner <= 0;
    end
  end

  // Monitor: compares every cycle against the head of the expected-grant queue.
  logic        prev_acc = 1'b0;
  logic [19:1] grant_addrs[$];

  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_outputs_zero",
          {mif.q_m_access, mif.instr_m_ack, mif.data_m_ack, mif.q_m_addr, mif.q_m_wr_en,
           mif.q_m_bytesel, mif.q_m_data_out, mif.instr_m_data_in, mif.data_m_data_in}, '0);
      prev_acc <= 1'b0;
    end else begin
      chk("instr_rdata_pass", mif.instr_m_data_in, mif.q_m_data_in);
      chk("data_rdata_pass", mif.data_m_data_in, mif.q_m_data_in);
      chk("access_vs_model", mif.q_m_access, m_owner != 0);
      if (!mif.q_m_access) begin
        chk("idle_bus_zero", {mif.q_m_addr, mif.q_m_wr_en, mif.q_m_bytesel, mif.q_m_data_out}, '0);
        chk("idle_no_ack", {mif.instr_m_ack, mif.data_m_ack}, '0);
        chk("idle_no_pending_grant", exp_q.size(), 0);
      end else begin
        chk("grant_predicted", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          chk("bus_fields",
              {mif.q_m_addr, mif.q_m_wr_en, mif.q_m_data_out, mif.q_m_bytesel},
              {exp_q[0].addr, exp_q[0].wr, exp_q[0].wdata, exp_q[0].bsel});
          chk("instr_ack", mif.instr_m_ack, mif.q_m_ack && exp_q[0].who == 1);
          chk("data_ack", mif.data_m_ack, mif.q_m_ack && exp_q[0].who == 2);
          if (mif.q_m_ack) exp_q.delete(0);
        end
        if (!prev_acc) grant_addrs.push_back(mif.q_m_addr);
      end
      prev_acc <= mif.q_m_access;
    end
  end

  // Shared-bus slave: one-cycle ack after a programmable or random wait.
  int          s_delay = -1;
  bit          s_spur_en = 1'b0;
  bit          s_force_spur = 1'b0;
  bit          s_fix = 1'b0;
  logic [15:0] s_fixval = 16'h0000;

  initial begin
    int  w;
    bit  busy;
    w    = 0;
    busy = 1'b0;
    mif.q_m_ack     = 1'b0;
    mif.q_m_data_in = 16'h0000;
    forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
        mif.q_m_ack = 1'b0;
        busy = 1'b0;
      end else if (mif.q_m_ack) begin
        mif.q_m_ack = 1'b0;
      end else if (mif.q_m_access) begin
        if (!busy) begin
          busy = 1'b1;
          w = (s_delay < 0) ? int'($urandom_range(3)) : s_delay;
        end
        if (w == 0) begin
          mif.q_m_ack     = 1'b1;
          mif.q_m_data_in = s_fix ? s_fixval : 16'($urandom);
          busy = 1'b0;
        end else begin
          w--;
        end
      end else begin
        mif.q_m_ack     = s_force_spur || (s_spur_en && $urandom_range(7) == 0);
        mif.q_m_data_in = 16'($urandom);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bit ia, da;
    mif.instr_m_addr    = '0;
    mif.instr_m_access  = 1'b0;
    mif.data_m_addr     = '0;
    mif.data_m_data_out = '0;
    mif.data_m_access   = 1'b0;
    mif.data_m_wr_en    = 1'b0;
    mif.data_m_bytesel  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_access", mif.q_m_access, 1'b0);
    tick();
    reset = 1'b1;

    // Instruction-only read, slave waits two cycles
    tick();
    s_delay = 2; s_fix = 1'b1; s_fixval = 16'hBEEF;
    mif.instr_m_addr = 19'h00100; mif.instr_m_access = 1'b1;
    @(negedge clk);
    chk("038_no_grant_same_cycle", mif.q_m_access, 1'b0);
    @(negedge clk);
    chk("038_grant_next_cycle", mif.q_m_access, 1'b1);
    chk("038_addr", mif.q_m_addr, 19'h00100);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      chk("038_no_data_ack", mif.data_m_ack, 1'b0);
      if (mif.instr_m_ack) begin
        got = 1'b1;
        chk("038_rdata", mif.instr_m_data_in, 16'hBEEF);
      end
    end
    chk("038_ack_seen", got, 1'b1);
    tick();
    mif.instr_m_access = 1'b0;
    @(negedge clk);
    chk("038_ack_one_cycle", mif.instr_m_ack, 1'b0);

    // Data write
    tick();
    s_delay = 1; s_fix = 1'b0;
    mif.data_m_addr = 19'h00200; mif.data_m_data_out = 16'h1234;
    mif.data_m_bytesel = 2'b01; mif.data_m_wr_en = 1'b1; mif.data_m_access = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("039_wr_en", mif.q_m_wr_en, 1'b1);
    chk("039_wdata", mif.q_m_data_out, 16'h1234);
    chk("039_bytesel", mif.q_m_bytesel, 2'b01);
    chk("039_addr", mif.q_m_addr, 19'h00200);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      chk("039_no_instr_ack", mif.instr_m_ack, 1'b0);
      if (mif.data_m_ack) got = 1'b1;
    end
    chk("039_ack_seen", got, 1'b1);
    tick();
    mif.data_m_access = 1'b0; mif.data_m_wr_en = 1'b0;

    // Continuous contention: instruction master wins every LIMIT+1 grants
    do_reset();
    grant_addrs.delete();
    s_delay = 0;
    mif.instr_m_addr = 19'h00AAA; mif.data_m_addr = 19'h00555;
    mif.instr_m_access = 1'b1; mif.data_m_access = 1'b1;
    for (int i = 0; i < 80 && grant_addrs.size() < 10; i++) @(negedge clk);
    chk("040_grant_count", grant_addrs.size() >= 10, 1'b1);
    tick();
    mif.instr_m_access = 1'b0; mif.data_m_access = 1'b0;
    for (int i = 0; i < 10; i++)
      if (i < grant_addrs.size())
        chk($sformatf("040_grant_%0d", i), grant_addrs[i],
            ((i % (LIMIT + 1)) == LIMIT) ? 19'h00AAA : 19'h00555);
    repeat (4) @(negedge clk);

    // Spurious slave ack while idle
    tick();
    s_force_spur = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("041_no_master_ack", {mif.instr_m_ack, mif.data_m_ack}, 2'b00);
      chk("041_stay_idle", mif.q_m_access, 1'b0);
    end
    tick();
    s_force_spur = 1'b0;

    // Reset during a data transfer, instruction request pending
    do_reset();
    s_delay = 6;
    mif.data_m_addr = 19'h00300; mif.data_m_wr_en = 1'b0; mif.data_m_access = 1'b1;
    mif.instr_m_addr = 19'h00123; mif.instr_m_access = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("042_data_granted", {mif.q_m_access, mif.q_m_addr}, {1'b1, 19'h00300});
    #1;
    reset = 1'b0;
    mif.data_m_access = 1'b0;
    #1;
    chk("042_access_drops_async", mif.q_m_access, 1'b0);
    chk("042_no_ack_in_reset", {mif.instr_m_ack, mif.data_m_ack}, 2'b00);
    tick();
    tick();
    s_delay = 1;
    reset = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      chk("042_no_stale_data_ack", mif.data_m_ack, 1'b0);
      if (mif.instr_m_ack) got = 1'b1;
    end
    chk("042_instr_granted", got, 1'b1);
    tick();
    mif.instr_m_access = 1'b0;

    // Randomised traffic
    s_delay = -1; s_spur_en = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      ia = mif.instr_m_ack;
      da = mif.data_m_ack;
      tick();
      if (ia) mif.instr_m_access = 1'b0;
      if (da) mif.data_m_access = 1'b0;
      if (!mif.instr_m_access && $urandom_range(2) == 0) begin
        mif.instr_m_addr   = 19'($urandom);
        mif.instr_m_access = 1'b1;
      end
      if (!mif.data_m_access && $urandom_range(2) == 0) begin
        mif.data_m_addr     = 19'($urandom);
        mif.data_m_data_out = 16'($urandom);
        mif.data_m_wr_en    = 1'($urandom);
        mif.data_m_bytesel  = 2'($urandom);
        mif.data_m_access   = 1'b1;
      end
    end
    tick();
    mif.instr_m_access = 1'b0; mif.data_m_access = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
